sim_watchdog: RTL and testbench
===============================

Name: sim_watchdog

Overview:
- Parametrised, synthesizable successor to the bench-level simulation timeout.
- Monitors N activity channels, each with its own idle timeout, plus a global run-time limit and a periodic progress tick.
- Sits in the test top beside the DUT and probes. Kick inputs are driven from DUT handshake or probe strobes.
- The bench polls the status outputs or waits on them to end or fail the test.

Parameters:
- N_CH, 4, number of monitored activity channels (1..32).
- CNT_W, 32, width of the global and tick counters.
- IDLE_W, 20, width of the per-channel idle counters.
- IDLE_LIMIT, 1024, cycles without a kick before a channel expires (1..2^IDLE_W-1).
- GLOBAL_LIMIT, 100000000, RUN cycles before a global timeout (1..2^CNT_W-1).
- TICK_PERIOD, 1000000, RUN cycles between progress ticks (1..2^CNT_W-1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; watchdog runs while high.
- kick  in  N_CH  per-channel activity strobe; any high cycle restarts that channel's idle count.
- ch_mask  in  N_CH  1 = channel monitored; 0 = channel ignored, its idle counter held at 0.
- clear  in  1  one-cycle pulse; clears expiry flags and all counters.
- progress_tick  out  1  one-cycle pulse every TICK_PERIOD RUN cycles.
- tick_count  out  16  number of ticks since reset or clear; saturates at 0xFFFF.
- ch_expired  out  N_CH  sticky per-channel idle-timeout flags.
- global_expired  out  1  sticky global timeout flag.
- fault  out  1  OR of ch_expired and global_expired.
- fault_ch  out  5  index of the first channel to expire; valid while any ch_expired bit is set.
- state  out  2  FSM state code.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE=0, RUN=1, EXPIRED=2.
  - IDLE -> RUN when enable=1. Counting starts on the next cycle.
  - RUN -> IDLE when enable=0. Counters and tick_count hold their values; flags hold.
  - RUN -> EXPIRED when global_expired or any ch_expired bit is set.
  - EXPIRED -> RUN on clear with enable=1; EXPIRED -> IDLE on clear with enable=0.
  - In EXPIRED all counters freeze and kicks are ignored.
- Channel idle counters:
  - In RUN, for a masked channel: kick=1 loads 0; otherwise the counter increments.
  - When the counter reaches IDLE_LIMIT-1 with no kick that cycle, ch_expired[i] sets on the next edge.
  - A kick in the same cycle as limit-reach wins; no expiry.
  - Clearing ch_mask[i] forces its counter to 0 but does not clear an already-set flag.
- fault_ch latch:
  - Latched on the first cycle any ch_expired bit sets.
  - If several channels expire on the same cycle, the lowest index is latched.
  - Not updated by later expiries until clear.
- Global counter:
  - Increments every RUN cycle.
  - On reaching GLOBAL_LIMIT-1, global_expired sets on the next edge.
  - If global and channel expiry occur on the same cycle, both flags set.
- Tick counter:
  - Counts RUN cycles and wraps at TICK_PERIOD-1.
  - On wrap, progress_tick=1 for exactly one cycle and tick_count increments (saturating at 0xFFFF).
  - First tick is the TICK_PERIOD-th RUN cycle after leaving IDLE from reset/clear.
- Latency: every flag and progress_tick is registered, one cycle after the triggering count.
- clear:
  - Priority over kick, enable and expiry in the same cycle.
  - Zeroes all counters, tick_count, all flags and fault_ch.
  - fault deasserts the following cycle.
- Width rules:
  - Counters are unsigned.
  - Parameters are checked at elaboration with a fatal error if out of range, e.g. IDLE_LIMIT >= 2^IDLE_W or N_CH > 32.

Decomposition:
- Shared package sim_watchdog_pkg holds:
  - wd_state_e enum (IDLE, RUN, EXPIRED) with 2-bit encoding.
  - localparam for the fault_ch width (5).
  - tick_count width constant (16).
- One sub-module: sim_watchdog_chan (one idle counter plus expiry flag), instantiated N_CH times in a generate loop.
- Top contains the FSM, global and tick counters, fault_ch priority encoder and latch.

Test Plan:
- Test parameters for all scenarios: N_CH=4, IDLE_LIMIT=8, GLOBAL_LIMIT=100, TICK_PERIOD=10.
- 1) Progress ticks: reset, enable=1, all channels kicked every 4 cycles -> progress_tick pulses on RUN cycles 10, 20, ... 90; tick_count=9; global_expired sets at cycle 100; state=2; fault=1; ch_expired=0.
- 2) Single idle channel: enable, ch_mask=4'b1111, kick channels 0, 1, 3 continuously, never channel 2 -> ch_expired=4'b0100 after 8 cycles; fault_ch=2; state=2; counters frozen.
- 3) Tie and masking: ch_mask=4'b0110, no kicks -> ch_expired=4'b0110 on the same cycle; fault_ch=1; bits 0 and 3 stay 0.
- 4) Kick at limit and mid-run disable: kick channel 0 exactly on idle count 7 -> no expiry. Drop enable for 20 cycles mid-run -> state=0, counters hold; re-enable -> global expiry occurs after 100 total RUN cycles, not wall cycles.
- 5) Clear from EXPIRED: after scenario 2 pulse clear with enable=1 -> next cycle fault=0, ch_expired=0, tick_count=0, state=1. clear with simultaneous kick and expiry -> clear wins.
- 6) Asynchronous reset mid-RUN: assert rst_n low between clock edges -> all outputs 0 immediately, without a clock edge; after release with enable=1, first tick is 10 RUN cycles later.

Source files
------------

// File: rtl/sim_watchdog_pkg.sv
// sim_watchdog_pkg: shared state encoding, output widths and the fault channel encoder
package sim_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } wd_state_e;

    localparam int FAULT_CH_W = 5;
    localparam int TICK_CNT_W = 16;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [FAULT_CH_W-1:0] first_set(input logic [31:0] v);
        logic [FAULT_CH_W-1:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) r = FAULT_CH_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/sim_watchdog_chan.sv
// sim_watchdog_chan: one activity channel, idle counter plus sticky expiry flag
module sim_watchdog_chan #(
    parameter int              IDLE_W     = 20,
    parameter longint unsigned IDLE_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic mask,
    input  logic kick,
    output logic hit,
    output logic expired
);

    logic [IDLE_W-1:0] cnt;

    // A kick on the limit cycle restarts the count instead of expiring.
    assign hit = run && mask && !kick && cnt == IDLE_W'(IDLE_LIMIT - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= (clear || !mask) ? '0 : run ? (kick ? '0 : cnt + 1'b1) : cnt;
            expired <= !clear && (expired || hit);
        end

endmodule

// File: rtl/sim_watchdog.sv
// sim_watchdog: per-channel idle timeouts, global run limit and progress ticks for test tops
module sim_watchdog
    import sim_watchdog_pkg::*;
#(
    parameter int              N_CH         = 4,
    parameter int              CNT_W        = 32,
    parameter int              IDLE_W       = 20,
    parameter longint unsigned IDLE_LIMIT   = 1024,
    parameter longint unsigned GLOBAL_LIMIT = 100000000,
    parameter longint unsigned TICK_PERIOD  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH-1:0]       kick,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic                  clear,
    output logic                  progress_tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [N_CH-1:0]       ch_expired,
    output logic                  global_expired,
    output logic                  fault,
    output logic [FAULT_CH_W-1:0] fault_ch,
    output logic [1:0]            state
);

    if (N_CH < 1 || N_CH > 32) $fatal(1, "sim_watchdog: N_CH must be 1..32");
    if (CNT_W < 1 || CNT_W > 63) $fatal(1, "sim_watchdog: CNT_W must be 1..63");
    if (IDLE_W < 1 || IDLE_W > 63) $fatal(1, "sim_watchdog: IDLE_W must be 1..63");
    if (IDLE_LIMIT == 0 || IDLE_LIMIT >= (64'd1 << IDLE_W))
        $fatal(1, "sim_watchdog: IDLE_LIMIT out of range");
    if (GLOBAL_LIMIT == 0 || GLOBAL_LIMIT >= (64'd1 << CNT_W))
        $fatal(1, "sim_watchdog: GLOBAL_LIMIT out of range");
    if (TICK_PERIOD == 0 || TICK_PERIOD >= (64'd1 << CNT_W))
        $fatal(1, "sim_watchdog: TICK_PERIOD out of range");

    wd_state_e        st;
    logic [CNT_W-1:0] gcnt, tcnt;
    logic [N_CH-1:0]  ch_hit;
    logic             run, g_hit, t_wrap, expire_now;

    assign run        = st == RUN;
    assign g_hit      = run && gcnt == CNT_W'(GLOBAL_LIMIT - 1);
    assign t_wrap     = run && tcnt == CNT_W'(TICK_PERIOD - 1);
    assign expire_now = g_hit || |ch_hit;
    assign fault      = |ch_expired || global_expired;
    assign state      = st;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        sim_watchdog_chan #(
            .IDLE_W    (IDLE_W),
            .IDLE_LIMIT(IDLE_LIMIT)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear),
            .run    (run),
            .mask   (ch_mask[c]),
            .kick   (kick[c]),
            .hit    (ch_hit[c]),
            .expired(ch_expired[c])
        );
    end

    // Expiry moves the FSM on the same edge that sets the flag, so counters freeze at once;
    // an expiry also swallows a tick due on that cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st             <= IDLE;
            gcnt           <= '0;
            tcnt           <= '0;
            tick_count     <= '0;
            progress_tick  <= 1'b0;
            global_expired <= 1'b0;
            fault_ch       <= '0;
        end else if (clear) begin
            st             <= enable ? RUN : IDLE;
            gcnt           <= '0;
            tcnt           <= '0;
            tick_count     <= '0;
            progress_tick  <= 1'b0;
            global_expired <= 1'b0;
            fault_ch       <= '0;
        end else begin
            st <= st == IDLE ? (enable ? RUN : IDLE) :
                  st == RUN  ? (expire_now ? EXPIRED : enable ? RUN : IDLE) : EXPIRED;
            if (run) begin
                gcnt <= gcnt + 1'b1;
                tcnt <= t_wrap ? '0 : tcnt + 1'b1;
            end
            progress_tick <= t_wrap && !expire_now;
            if (t_wrap && !expire_now && tick_count != '1)
                tick_count <= tick_count + 1'b1;
            global_expired <= global_expired || g_hit;
            if (!(|ch_expired) && |ch_hit)
                fault_ch <= first_set(32'(ch_hit));
        end

endmodule

// File: tb/tb_sim_watchdog.sv
// tb_sim_watchdog: directed scenarios for sim_watchdog with hand-computed expectations
module tb_sim_watchdog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  kick = '0;
    logic [3:0]  ch_mask = '0;
    logic        clear = 1'b0;
    logic        progress_tick;
    logic [15:0] tick_count;
    logic [3:0]  ch_expired;
    logic        global_expired;
    logic        fault;
    logic [4:0]  fault_ch;
    logic [1:0]  state;
    int          checks = 0;
    int          errors = 0;

    sim_watchdog #(
        .N_CH        (4),
        .CNT_W       (32),
        .IDLE_W      (20),
        .IDLE_LIMIT  (8),
        .GLOBAL_LIMIT(100),
        .TICK_PERIOD (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .kick          (kick),
        .ch_mask       (ch_mask),
        .clear         (clear),
        .progress_tick (progress_tick),
        .tick_count    (tick_count),
        .ch_expired    (ch_expired),
        .global_expired(global_expired),
        .fault         (fault),
        .fault_ch      (fault_ch),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        kick = '0;
        ch_mask = '0;
        clear = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        step(2);
        check("rst_state", state, 0);
        check("rst_tick_count", tick_count, 0);
        check("rst_ch_expired", ch_expired, 0);
        check("rst_global", global_expired, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_ch", fault_ch, 0);
        check("rst_tick", progress_tick, 0);
        rst_n = 1'b1;

        // Progress ticks and global expiry; edge e leaves e-1 RUN cycles done.
        ch_mask = 4'hf;
        enable = 1'b1;
        for (int e = 1; e <= 101; e++) begin
            kick = (e % 4 == 0) ? 4'hf : 4'h0;
            step();
            check("s1_tick", progress_tick, e >= 11 && e <= 91 && (e - 1) % 10 == 0);
            check("s1_global", global_expired, e >= 101);
        end
        check("s1_tick_count", tick_count, 9);
        check("s1_state", state, 2);
        check("s1_fault", fault, 1);
        check("s1_ch_expired", ch_expired, 0);
        step(20);
        check("s1_frozen_ticks", tick_count, 9);
        check("s1_frozen_state", state, 2);

        // Single idle channel.
        do_reset();
        ch_mask = 4'hf;
        kick = 4'b1011;
        enable = 1'b1;
        step(8);
        check("s2_pre_exp", ch_expired, 0);
        check("s2_pre_state", state, 1);
        step();
        check("s2_ch_expired", ch_expired, 4'b0100);
        check("s2_fault_ch", fault_ch, 2);
        check("s2_state", state, 2);
        check("s2_fault", fault, 1);
        step(15);
        check("s2_frozen_ticks", tick_count, 0);
        check("s2_frozen_global", global_expired, 0);
        check("s2_held_exp", ch_expired, 4'b0100);

        // Clear from EXPIRED, then clear on an expiry cycle.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("s5_fault", fault, 0);
        check("s5_ch_expired", ch_expired, 0);
        check("s5_tick_count", tick_count, 0);
        check("s5_state", state, 1);
        check("s5_fault_ch", fault_ch, 0);
        step(7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("s5_clear_wins", ch_expired, 0);
        check("s5_clear_state", state, 1);
        step(7);
        check("s5_restart_pre", ch_expired, 0);
        step();
        check("s5_restart_exp", ch_expired, 4'b0100);
        check("s5_restart_fch", fault_ch, 2);

        // Tie between two monitored channels; unmonitored ones stay quiet.
        do_reset();
        ch_mask = 4'b0110;
        enable = 1'b1;
        step(8);
        check("s3_pre_exp", ch_expired, 0);
        step();
        check("s3_ch_expired", ch_expired, 4'b0110);
        check("s3_fault_ch", fault_ch, 1);
        check("s3_state", state, 2);

        // Kick on the limit cycle, then a 20-cycle disable in the middle of the run.
        do_reset();
        ch_mask = 4'b0001;
        enable = 1'b1;
        step(8);
        kick = 4'b0001;
        step();
        check("s4_kick_at_limit", ch_expired, 0);
        check("s4_kick_state", state, 1);
        step(21);
        enable = 1'b0;
        step();
        check("s4_idle_state", state, 0);
        check("s4_idle_ticks", tick_count, 3);
        step(19);
        check("s4_hold_state", state, 0);
        check("s4_hold_ticks", tick_count, 3);
        check("s4_hold_global", global_expired, 0);
        enable = 1'b1;
        step(70);
        check("s4_pre_global", global_expired, 0);
        check("s4_pre_state", state, 1);
        step();
        check("s4_global", global_expired, 1);
        check("s4_state", state, 2);
        check("s4_tick_count", tick_count, 9);
        check("s4_ch_expired", ch_expired, 0);

        // Asynchronous reset between edges.
        do_reset();
        ch_mask = 4'hf;
        kick = 4'hf;
        enable = 1'b1;
        step(15);
        check("s6_pre_ticks", tick_count, 1);
        check("s6_pre_state", state, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_state", state, 0);
        check("s6_async_ticks", tick_count, 0);
        check("s6_async_fault", fault, 0);
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step();
            check("s6_tick", progress_tick, e == 11);
        end
        check("s6_tick_count", tick_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
